// File: rtl/fetch_stage.sv
// Fetch stage: PC register, BOOT/RUN/HALT control and IF/ID pipeline register.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects halt and set a sticky flag.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        halted,
    output logic        fetch_misaligned
);

    localparam int unsigned XLEN   = 32;
    localparam logic [XLEN-1:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [XLEN-1:0] INSTR_EBREAK = 32'h0010_0073;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   ipc_q, ipc_d;
    logic [XLEN-1:0]   ip4_q, ip4_d;
    logic              mis_q, mis_d;

    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   target_aligned;
    logic              redir_mis;
    logic              redir_trap;

    assign pc_plus4       = pc_q + XLEN'(4);
    assign redir_mis      = (redirect_target[1:0] != 2'b00);
    assign redir_trap     = TRAP_EN && redir_mis;
    // Low bits are dropped on load; with the trap enabled a misaligned target never loads.
    assign target_aligned = {redirect_target[XLEN-1:2], 2'b00};

    // Next-state and IF/ID update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ip4_d   = ip4_q;
        mis_d   = mis_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_HALT: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    instr_d = INSTR_NOP;
                    if (redir_trap) begin
                        state_d = ST_HALT;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        pc_d    = target_aligned;
                    end
                end else if (state_q == ST_RUN) begin
                    if (!stall) begin
                        valid_d = 1'b1;
                        instr_d = imem_rdata;
                        ipc_d   = pc_q;
                        ip4_d   = pc_plus4;
                        // EBREAK is passed down but the PC parks on it
                        if (imem_rdata == INSTR_EBREAK) begin
                            state_d = ST_HALT;
                        end else begin
                            pc_d = pc_plus4;
                        end
                    end
                end else begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= INSTR_NOP;
            ipc_q   <= '0;
            ip4_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ip4_q   <= ip4_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_addr        = pc_q;
    assign if_id_valid      = valid_q;
    assign if_id_pc         = ipc_q;
    assign if_id_pc_plus4   = ip4_q;
    assign if_id_instr      = instr_q;
    assign halted           = (state_q == ST_HALT);
    assign fetch_misaligned = mis_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a reference model pushes expected IF/ID state per cycle.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBRK   = 32'h0010_0073;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        halted;
    logic        fetch_misaligned;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .if_id_valid      (if_id_valid),
        .if_id_pc         (if_id_pc),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .if_id_instr      (if_id_instr),
        .halted           (halted),
        .fetch_misaligned (fetch_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: word i holds i, except one optional EBREAK location
    logic [31:0] ebreak_addr;
    assign imem_rdata = (imem_addr == ebreak_addr) ? EBRK : {2'b00, imem_addr[31:2]};

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] p4;
        logic [31:0] ins;
        logic        h;
        logic        m;
        logic [31:0] a;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_bad = 0;

    int          m_st;   // 0 boot, 1 run, 2 halt
    logic [31:0] m_pc, m_ipc, m_ip4, m_ins;
    logic        m_v, m_mis;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model_snap();
        exp_t e;
        e.v   = m_v;
        e.pc  = m_ipc;
        e.p4  = m_ip4;
        e.ins = m_ins;
        e.h   = (m_st == 2);
        e.m   = m_mis;
        e.a   = m_pc;
        return e;
    endfunction

    task automatic compare(input string pfx, input exp_t e);
        check({pfx, "_valid"}, 32'(if_id_valid), 32'(e.v));
        check({pfx, "_pc"},    if_id_pc, e.pc);
        check({pfx, "_pc4"},   if_id_pc_plus4, e.p4);
        check({pfx, "_instr"}, if_id_instr, e.ins);
        check({pfx, "_halt"},  32'(halted), 32'(e.h));
        check({pfx, "_mis"},   32'(fetch_misaligned), 32'(e.m));
        check({pfx, "_addr"},  imem_addr, e.a);
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_pc  = RST_PC;
        m_v   = 1'b0;
        m_ins = NOP;
        m_ipc = 32'h0;
        m_ip4 = 32'h0;
        m_mis = 1'b0;
    endtask

    // One clock: drive inputs at negedge, predict, check #1 after posedge
    task automatic cycle(input logic s, input logic rv, input logic [31:0] rt);
        logic [31:0] rd;
        exp_t        e;
        stall           = s;
        redirect_valid  = rv;
        redirect_target = rt;
        rd = (m_pc == ebreak_addr) ? EBRK : {2'b00, m_pc[31:2]};
        if (m_st == 0) begin
            m_st = 1;
        end else if (rv) begin
            m_v   = 1'b0;
            m_ins = NOP;
            if (TRAP && rt[1:0] != 2'b00) begin
                m_st  = 2;
                m_mis = 1'b1;
            end else begin
                m_st = 1;
                m_pc = rt & 32'hFFFF_FFFC;
            end
        end else if (m_st == 1) begin
            if (!s) begin
                m_v   = 1'b1;
                m_ins = rd;
                m_ipc = m_pc;
                m_ip4 = m_pc + 32'd4;
                if (rd == EBRK) m_st = 2;
                else m_pc = m_pc + 32'd4;
            end
        end else begin
            m_v = 1'b0;
        end
        exp_q.push_back(model_snap());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        compare("cyc", e);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n           = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        ebreak_addr     = 32'hFFFF_FFFF;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare("rst", model_snap());
        check("rst_instr_lit", if_id_instr, 32'h13);
        check("rst_addr_lit", imem_addr, 32'h100);

        // BOOT ignores redirect, then sequential fetch
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 32'h300);
        cycle(1'b0, 1'b0, 32'h0);
        check("r29_pc0", if_id_pc, 32'h100);
        check("r29_ins0", if_id_instr, 32'h40);
        cycle(1'b0, 1'b0, 32'h0);
        check("r29_pc1", if_id_pc, 32'h104);
        check("r29_ins1", if_id_instr, 32'h41);

        repeat (3) cycle(1'b1, 1'b0, 32'h0);
        check("r30_addr", imem_addr, 32'h108);
        check("r30_pc", if_id_pc, 32'h104);
        cycle(1'b0, 1'b0, 32'h0);
        check("r30_resume", if_id_pc, 32'h108);

        // Redirect beats stall
        cycle(1'b1, 1'b1, 32'h200);
        check("r31_addr", imem_addr, 32'h200);
        check("r31_ins", if_id_instr, 32'h13);
        cycle(1'b0, 1'b0, 32'h0);
        check("r31_pc", if_id_pc, 32'h200);
        cycle(1'b0, 1'b0, 32'h0);

        // EBREAK halts; stall ignored in HALT; redirect resumes
        ebreak_addr = 32'h10C;
        cycle(1'b0, 1'b1, 32'h10C);
        cycle(1'b0, 1'b0, 32'h0);
        check("r32_ins", if_id_instr, EBRK);
        check("r32_v", 32'(if_id_valid), 32'd1);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("r32_halt", 32'(halted), 32'd1);
        check("r32_addr", imem_addr, 32'h10C);
        cycle(1'b1, 1'b1, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);

        // Misaligned redirect
        cycle(1'b0, 1'b1, 32'h202);
        check("r33_mis", 32'(fetch_misaligned), TRAP ? 32'd1 : 32'd0);
        check("r33_addr", imem_addr, TRAP ? 32'h8 : 32'h200);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h200);
        cycle(1'b0, 1'b0, 32'h0);

        // PC wrap
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'h0);
        check("wrap_p4", if_id_pc_plus4, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);

        // Async reset mid-stall at pc 0x120
        cycle(1'b0, 1'b1, 32'h118);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("r34_pre", imem_addr, 32'h120);
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare("r34", model_snap());

        // Reset while halted
        @(negedge clk);
        stall = 1'b0;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        check("hrst_pre", 32'(halted), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare("hrst", model_snap());

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the address of the first fetched instruction after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  downstream not ready; hold PC and IF/ID register.
REQ-005 SHALL have port redirect_valid  input  1  branch/jump taken; load redirect_target.
REQ-006 SHALL have port redirect_target  input  32  new byte address of the next fetch.
REQ-007 SHALL have port imem_addr  output  32  byte address driven to the combinational instruction memory.
REQ-008 SHALL have port imem_rdata  input  32  instruction word returned in the same cycle.
REQ-009 SHALL have port if_id_valid  output  1  IF/ID register holds a real instruction.
REQ-010 SHALL have port if_id_pc  output  32  address of the instruction in IF/ID.
REQ-011 SHALL have port if_id_pc_plus4  output  32  if_id_pc + 4.
REQ-012 SHALL have port if_id_instr  output  32  registered instruction word.
REQ-013 SHALL have port halted  output  1  high while the state is HALT.
REQ-014 SHALL have port fetch_misaligned  output  1  sticky misaligned-redirect flag.

Function
REQ-015 SHALL drive imem_addr = pc combinationally, with no added latency.
REQ-016 SHALL implement states BOOT, RUN and HALT.
REQ-017 BOOT SHALL last exactly one cycle after reset release, capture nothing, then go to RUN.
REQ-018 RUN, no redirect, no stall: SHALL set pc <= pc+4 (mod 2^32), if_id_instr <= imem_rdata, if_id_pc <= pc, if_id_pc_plus4 <= pc+4 and if_id_valid <= 1.
REQ-019 RUN with stall and no redirect: SHALL hold pc and all IF/ID outputs unchanged.
REQ-020 redirect_valid SHALL take priority over stall in RUN and HALT: pc <= redirect_target, if_id_valid <= 0, if_id_instr <= 32'h0000_0013 (NOP), state <= RUN.
REQ-021 RUN, capturing imem_rdata == 32'h0010_0073 (EBREAK) without redirect or stall: SHALL pass EBREAK with if_id_valid=1, hold pc at the EBREAK address, then enter HALT.
REQ-022 HALT without redirect: SHALL hold pc, set if_id_valid <= 0 and ignore stall.
REQ-023 PC wrap: 32'hFFFF_FFFC + 4 SHALL yield 32'h0000_0000 with no flag.
REQ-024 Redirect in BOOT SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately set pc=RESET_PC, state=BOOT, if_id_valid=0, if_id_instr=32'h0000_0013, if_id_pc=0, if_id_pc_plus4=0, halted=0, fetch_misaligned=0, including mid-stall and in HALT.
REQ-026 Reset release SHALL be followed by BOOT, so the first valid IF/ID capture occurs on the second rising edge after release.

Configuration
REQ-027 Macro FETCH_MISALIGN_TRAP_EN defined: a redirect with redirect_target[1:0] != 0 SHALL leave pc unchanged, flush IF/ID, enter HALT and set fetch_misaligned=1 until reset; HALT exit by redirect SHALL still be permitted.
REQ-028 FETCH_MISALIGN_TRAP_EN undefined: redirect_target[1:0] SHALL be forced to 2'b00 on load and fetch_misaligned SHALL be tied 0.

Verification
REQ-029 Reset with RESET_PC=32'h100, memory word i = i -> after BOOT, IF/ID shows (pc 0x100, instr 0x40), (0x104, 0x41), ... one per cycle.
REQ-030 Stall for 3 cycles at pc 0x108 -> IF/ID frozen at 0x104/0x41 and imem_addr held at 0x108; release resumes at 0x108.
REQ-031 redirect_valid=1, redirect_target=0x200 with stall=1 -> next cycle if_id_valid=0, instr 0x13, imem_addr=0x200; following cycle captures 0x200.
REQ-032 EBREAK at 0x10C -> IF/ID valid with 0x0010_0073 for one cycle, then halted=1, if_id_valid=0, imem_addr stuck at 0x10C; redirect to 0x000 resumes RUN.
REQ-033 With FETCH_MISALIGN_TRAP_EN, redirect to 0x202 -> fetch_misaligned=1, halted=1, pc unchanged; without the macro -> pc=0x200, flag 0.
REQ-034 rst_n asserted mid-RUN at pc 0x120 -> outputs reach reset values without a clock edge; pc returns to RESET_PC.
